// File: rtl/tea_rx_loader.sv
// UART 8N1 receiver that assembles bytes into a 64-bit TEA data block or a 128-bit key.
// The block is delivered via valid/ready and the key via a one-cycle load strobe.
module tea_rx_loader #(
    parameter int unsigned CLKS_PER_BIT = 104,
    parameter int unsigned BLOCK_BYTES  = 8,
    parameter int unsigned KEY_BYTES    = 16
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_rx,
    input  logic         i_key_update,
    output logic [63:0]  o_block,
    output logic         o_block_valid,
    input  logic         i_block_ready,
    output logic [127:0] o_key,
    output logic         o_key_load,
    output logic         o_frame_err,
    output logic         o_overrun,
    output logic         o_busy
);

    localparam int unsigned HALF = CLKS_PER_BIT / 2;
    localparam int unsigned TW   = $clog2(CLKS_PER_BIT);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_t;

    state_t          r_state;
    logic            r_rx_meta;
    logic            r_rx_s;
    logic            r_armed;
    logic [TW-1:0]   r_timer;
    logic [2:0]      r_bit_cnt;
    logic [7:0]      r_rx_byte;
    logic            r_byte_done;
    logic            r_frame_err;

    logic [4:0]      r_cnt;
    logic            r_tgt;
    logic [119:0]    r_sr;
    logic [63:0]     r_block;
    logic            r_block_valid;
    logic [127:0]    r_key;
    logic            r_key_load;
    logic            r_overrun;

    logic            w_tgt;
    logic [4:0]      w_base;
    logic [4:0]      w_cnt_inc;
    logic [127:0]    w_sr_next;
    logic            w_drop;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= i_rx;
            r_rx_s    <= r_rx_meta;
        end
    end

    // r_armed blocks a new start until the line has been seen high after a frame error.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= StIdle;
            r_armed     <= 1'b1;
            r_timer     <= '0;
            r_bit_cnt   <= '0;
            r_rx_byte   <= '0;
            r_byte_done <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_byte_done <= 1'b0;
            r_frame_err <= 1'b0;
            case (r_state)
                StIdle: begin
                    r_timer <= '0;
                    if (r_rx_s) begin
                        r_armed <= 1'b1;
                    end else if (r_armed) begin
                        r_state <= StStart;
                    end
                end
                StStart: begin
                    if (r_timer == TW'(HALF - 1)) begin
                        r_timer   <= '0;
                        r_bit_cnt <= '0;
                        r_state   <= r_rx_s ? StIdle : StData;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                StData: begin
                    if (r_timer == TW'(CLKS_PER_BIT - 1)) begin
                        r_timer   <= '0;
                        r_rx_byte <= {r_rx_s, r_rx_byte[7:1]};
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                        if (r_bit_cnt == 3'd7) begin
                            r_state <= StStop;
                        end
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                StStop: begin
                    if (r_timer == TW'(CLKS_PER_BIT - 1)) begin
                        r_timer <= '0;
                        r_state <= StIdle;
                        if (r_rx_s) begin
                            r_byte_done <= 1'b1;
                        end else begin
                            r_frame_err <= 1'b1;
                            r_armed     <= 1'b0;
                        end
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    // A block accepted on this edge frees the output register for a new completion.
    always_comb begin
        w_tgt     = i_key_update;
        w_base    = (w_tgt != r_tgt) ? 5'd0 : r_cnt;
        w_cnt_inc = w_base + 5'd1;
        w_sr_next = {r_sr, r_rx_byte};
        w_drop    = !w_tgt && r_block_valid && !i_block_ready;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt         <= '0;
            r_tgt         <= 1'b0;
            r_sr          <= '0;
            r_block       <= '0;
            r_block_valid <= 1'b0;
            r_key         <= '0;
            r_key_load    <= 1'b0;
            r_overrun     <= 1'b0;
        end else begin
            r_key_load <= 1'b0;
            if (r_block_valid && i_block_ready) begin
                r_block_valid <= 1'b0;
            end
            if (r_byte_done) begin
                if (w_drop) begin
                    r_overrun <= 1'b1;
                end else begin
                    r_sr  <= w_sr_next[119:0];
                    r_tgt <= w_tgt;
                    if (!w_tgt && (w_cnt_inc == 5'(BLOCK_BYTES))) begin
                        r_cnt         <= '0;
                        r_block       <= w_sr_next[63:0];
                        r_block_valid <= 1'b1;
                    end else if (w_tgt && (w_cnt_inc == 5'(KEY_BYTES))) begin
                        r_cnt      <= '0;
                        r_key      <= w_sr_next;
                        r_key_load <= 1'b1;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
            end
        end
    end

    assign o_block       = r_block;
    assign o_block_valid = r_block_valid;
    assign o_key         = r_key;
    assign o_key_load    = r_key_load;
    assign o_frame_err   = r_frame_err;
    assign o_overrun     = r_overrun;
    assign o_busy        = (r_state != StIdle) || (r_cnt != 5'd0) || r_byte_done;

endmodule
